ahb_lite_sram_slave: RTL
========================

// Module: ahb_lite_sram_slave
// PURPOSE
//  Parametrised AHB-Lite slave: word-organised SRAM with byte-lane writes and programmable wait states.
//  Out-of-range, misaligned and oversize accesses get the two-cycle ERROR response.
//  Sits behind the decoder/mux as the reusable memory target for the AHBLite RTL design.
//  Width defaults come from the Definitions package.
// PARAMETERS
//  DATAWIDTH    32      HWDATA/HRDATA width; 32 or 64
//  ADDRWIDTH    32      HADDR width
//  DEPTH        1024    number of DATAWIDTH-bit words
//  WAIT_STATES  0       HREADYOUT-low cycles inserted per OKAY data phase; 0..15
//  BASE_ADDR    0       byte base address of the region; DATAWIDTH/8 aligned
// PORTS
//  HCLK       in   1          clock; one clock domain
//  HRESETn    in   1          reset; asynchronous, active-low
//  HSEL       in   1          slave select from decoder
//  HADDR      in   ADDRWIDTH  byte address
//  HWRITE     in   1          1=write, 0=read
//  HSIZE      in   3          transfer size, 2**HSIZE bytes
//  HBURST     in   3          burst type; accepted, no effect on behaviour
//  HTRANS     in   2          IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HREADY     in   1          bus ready from the mux; qualifies the address phase
//  HWDATA     in   DATAWIDTH  write data, valid in the data phase
//  HRDATA     out  DATAWIDTH  read data
//  HREADYOUT  out  1          slave ready
//  HRESP      out  1          0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, no access pending.
//  - Memory contents are not reset.
//  - Reset asserted mid-transfer aborts it; no array write occurs.
//  Address-phase capture:
//  - Capture on a rising edge with HSEL & HREADY & HTRANS[1].
//  - Captured: HADDR, HWRITE, HSIZE, error flag.
//  - IDLE/BUSY, or HSEL=0: no capture; the next data phase is zero-wait OKAY.
//  Error flag is set when any of these holds:
//  - (HADDR-BASE_ADDR) >= DEPTH*DATAWIDTH/8, or HADDR < BASE_ADDR
//  - HSIZE > log2(DATAWIDTH/8)
//  - HADDR not aligned to 2**HSIZE
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//  - IDLE -> WAIT: OKAY capture with WAIT_STATES>0; a counter loads WAIT_STATES.
//  - WAIT: HREADYOUT=0; counter decrements each cycle; at 1 go to IDLE, whose cycle completes the data phase.
//  - IDLE -> ERR1: error capture. ERR1 drives HREADYOUT=0, HRESP=1.
//  - ERR1 -> ERR2. ERR2 drives HREADYOUT=1, HRESP=1.
//  - ERR2 -> IDLE, or WAIT/ERR1 if a new transfer is captured in ERR2.
//  - ERR2 capture still happens: the master can cancel, but a captured NONSEQ is honoured.
//  - With WAIT_STATES=0, an OKAY transfer stays in IDLE and completes in one data-phase cycle.
//  Data phase and pipelining:
//  - The final HREADYOUT=1 cycle of a data phase is also a legal address phase; back-to-back transfers take no bubble.
//  - Word index = (addr-BASE_ADDR) >> log2(DATAWIDTH/8). Lanes are little-endian.
//  - Write: lanes [off, off+2**size) take the HWDATA bytes at the edge ending the OKAY data phase; other lanes keep their contents.
//  - Erroring writes never modify memory.
//  - Read: HRDATA = full word at the captured index, combinational from the array during the data phase.
//  - HRDATA = 0 outside read data phases and during ERR1/ERR2.
//  - Read immediately after a write to the same word returns the new data; the write commits before the read data phase.
// TESTING
//  - Reset with HRESETn=0 mid-WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0, target word unchanged.
//  - WAIT_STATES=0: NONSEQ write word 0xA5A5_1234 @BASE+0x10 then read @0x10 back-to-back -> HRDATA=0xA5A5_1234, HREADYOUT never low.
//  - Byte write 0xEF @BASE+0x11 (HSIZE=0) over word 0 -> read @0x10 returns 0x0000_EF00.
//  - WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, data valid in the 4th.
//  - Read @BASE+DEPTH*4 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, then OKAY.
//  - Halfword write @BASE+0x1 -> ERROR response, memory unchanged.
//  - HTRANS=BUSY or IDLE with HSEL=1 -> zero-wait OKAY, no access.
//  - SEQ INCR4 burst with BUSY in mid-burst -> four words written, no extra waits.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: byte-lane writes, programmable wait states,
// two-cycle ERROR for out-of-range, misaligned and oversize accesses.
module ahb_lite_sram_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDRWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic [DATAWIDTH-1:0] HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int NB = DATAWIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam longint BYTES = longint'(DEPTH) * NB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state;
  logic [3:0] cnt;
  logic ready_q;
  logic resp_q;
  logic a_valid;
  logic a_write;
  logic [2:0] a_size;
  logic [IW-1:0] a_idx;
  logic [LB-1:0] a_off;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [63:0] off;
  logic [7:0] amask;
  logic below;
  logic above;
  logic oversize;
  logic misalign;
  logic err;
  logic cap;
  logic wr_en;
  logic [NB-1:0] be;
  logic unused_ok;

  assign off = 64'(HADDR) - 64'(BASE_ADDR);
  assign below = HADDR < BASE_ADDR;
  assign above = off >= 64'(BYTES);
  assign oversize = HSIZE > 3'(LB);
  assign amask = ~(8'hff << HSIZE);
  assign misalign = |(HADDR[7:0] & amask);
  assign err = below | above | oversize | misalign;

  // Only accept a new address phase while our own data phase can end.
  assign cap = HSEL & HREADY & HTRANS[1] & ready_q;

  assign wr_en = (state == S_IDLE) & a_valid & a_write;
  assign unused_ok = ^{HBURST, HTRANS[0], off};

  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(a_off)) &&
              (i < int'(a_off) + (1 << a_size));
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[a_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HRDATA = (a_valid && !a_write) ? mem[a_idx] : '0;
  assign HREADYOUT = ready_q;
  assign HRESP = resp_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_size  <= '0;
      a_idx   <= '0;
      a_off   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_ERR2: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          a_valid <= 1'b0;
          if (cap) begin
            a_write <= HWRITE;
            a_size  <= HSIZE;
            a_idx   <= off[LB +: IW];
            a_off   <= off[LB-1:0];
            if (err) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else begin
              a_valid <= 1'b1;
              if (WAIT_STATES > 0) begin
                state   <= S_WAIT;
                ready_q <= 1'b0;
                cnt     <= 4'(WAIT_STATES);
              end
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
